mant_align_shift: RTL and testbench
===================================

// Module: mant_align_shift
// PURPOSE
//  Mantissa alignment stage directly downstream of the exponent-difference stage in the FP adder.
//  Takes both 24-bit mantissas (hidden bit included), expbig, expdiff and muxctrl; routes the
//  smaller-exponent mantissa into a 27-bit {M,G,R,S} word and right-shifts it by expdiff.
//  Shifts iteratively, SHIFT_STEP bits per cycle, folding shifted-out bits into sticky.
//  Valid/ready handshake on both sides; feeds the significand add/sub stage.
// PARAMETERS
//  MAN_W       24  mantissa width incl. hidden bit
//  SHIFT_STEP  4   max shift positions per cycle (1..8)
// PORTS
//  clk          in   1        single clock, all state on rising edge
//  rst_n        in   1        asynchronous, active-low reset
//  in_valid     in   1        operand set valid
//  in_ready     out  1        stage can accept (high only in IDLE)
//  manA         in   MAN_W    mantissa of operand A
//  manB         in   MAN_W    mantissa of operand B
//  expbig       in   8        larger exponent, passed through
//  expdiff      in   8        |expA-expB|, unsigned
//  muxctrl      in   1        1: expB larger (A is shifted); 0: expA >= expB (B is shifted)
//  out_valid    out  1        aligned result valid
//  out_ready    in   1        consumer accepts result
//  man_big      out  MAN_W    unshifted mantissa
//  man_small    out  MAN_W+3  aligned {mantissa,G,R,S}
//  exp_out      out  8        registered expbig
//  swapped      out  1        registered muxctrl
// BEHAVIOUR
//  Reset (rst_n=0, any time): state=IDLE; in_ready=1, out_valid=0, all data outputs 0.
//  FSM IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_valid&in_ready loads man_big=(muxctrl?manB:manA),
//     work={(muxctrl?manA:manB),3'b000}, rem=min(expdiff,MAN_W+2), exp_out, swapped.
//     next = (rem==0) ? DONE : SHIFT.
//   SHIFT: k=min(rem,SHIFT_STEP); work=work>>k with new bit0 = OR of old bits [k:0];
//     rem-=k; go DONE when rem reaches 0 this cycle.
//   DONE: out_valid=1, man_small=work; outputs stable while out_valid&!out_ready;
//     on out_ready -> IDLE (in_ready rises next cycle; no same-cycle accept).
//  Latency: out_valid rises 1+ceil(rem/SHIFT_STEP) cycles after the accepting edge.
//  Saturation: expdiff >= MAN_W+2 (26) -> word shifted fully; man_small=27'h0000001 for any
//   nonzero small mantissa, 0 for zero mantissa. expdiff up to 255 is legal.
//  in_valid while busy: ignored (in_ready=0); inputs need not be held after acceptance.
//  Sticky is cumulative: once set it never clears within an operation.
//  No mantissa comparison when expdiff=0: B is the "small" operand, shift 0.
// STRUCTURE
//  Package fp_align_pkg: MAN_W, GRS_W=3, SAT_SHIFT=MAN_W+2, state enum {IDLE,SHIFT,DONE}.
//  Sub-module sticky_rshift (combinational): in word[MAN_W+2:0], k[3:0] <= SHIFT_STEP
//   -> shifted word with sticky OR folded into bit0. Top holds FSM, rem counter, regs.
// TESTING (SHIFT_STEP=4)
//  1 muxctrl=0, manA=24'hC00000, manB=24'h800000, expdiff=1 -> man_big=C00000,
//    man_small=27'h2000000, out_valid 2 cycles after accept.
//  2 muxctrl=1, manA=24'h800001, manB=24'hFFFFFF, expdiff=3 -> man_big=FFFFFF,
//    man_small=27'h0800001, swapped=1.
//  3 expdiff=0, manB=24'hABCDEF -> man_small=27'h55E6F78, out_valid 1 cycle after accept.
//  4 expdiff=10 -> out_valid exactly 4 cycles after accept; expdiff=40, manB=24'h800000
//    -> man_small=27'h0000001, 8 cycles.
//  5 out_ready=0 for 5 cycles in DONE -> outputs unchanged, in_ready=0 throughout;
//    in_valid pulses while busy are dropped.
//  6 rst_n low mid-SHIFT (async, between edges) -> out_valid=0, in_ready=1 immediately;
//    next operation after release produces correct result.

Source files
------------

// File: rtl/fp_align_pkg.sv
// Shared constants, FSM state type and shift clamp for the FP adder mantissa alignment stage.
package fp_align_pkg;
   localparam int MAN_W     = 24;
   localparam int GRS_W     = 3;
   localparam int WORD_W    = MAN_W + GRS_W;
   localparam int SAT_SHIFT = MAN_W + 2;
   localparam int REM_W     = 5;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // Past SAT_SHIFT positions every bit has already been folded into sticky.
   function automatic logic [REM_W-1:0] clamp_shift(input logic [7:0] d);
      return (d >= 8'(SAT_SHIFT)) ? REM_W'(SAT_SHIFT) : d[REM_W-1:0];
   endfunction
endpackage

// File: rtl/sticky_rshift.sv
// Combinational right shift of the {M,G,R,S} word by k (0..8), OR-ing bits [k:0] into bit 0.
module sticky_rshift
   import fp_align_pkg::*;
(
   input  logic [WORD_W-1:0] word,
   input  logic [3:0]        k,
   output logic [WORD_W-1:0] shifted
);
   logic [8:0]        lo_hit;
   logic [WORD_W-1:0] sr;

   // Bits [k:0] either leave the word or land in bit 0; both feed sticky.
   generate
      for (genvar gi = 0; gi < 9; gi++) begin : g_lo
         assign lo_hit[gi] = word[gi] && (4'(gi) <= k);
      end
   endgenerate

   assign sr      = word >> k;
   assign shifted = {sr[WORD_W-1:1], sr[0] | (|lo_hit)};
endmodule

// File: rtl/mant_align_shift.sv
// Aligns the smaller-exponent mantissa by iterative sticky right shifts, SHIFT_STEP bits per cycle.
module mant_align_shift
   import fp_align_pkg::*;
#(
   parameter int SHIFT_STEP = 4
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MAN_W-1:0]  manA,
   input  logic [MAN_W-1:0]  manB,
   input  logic [7:0]        expbig,
   input  logic [7:0]        expdiff,
   input  logic              muxctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MAN_W-1:0]  man_big,
   output logic [WORD_W-1:0] man_small,
   output logic [7:0]        exp_out,
   output logic              swapped
);
   state_t            state_reg;
   logic [WORD_W-1:0] work_reg;
   logic [WORD_W-1:0] work_next;
   logic [REM_W-1:0]  rem_reg;
   logic [REM_W-1:0]  rem_next;
   logic [REM_W-1:0]  rem_load;
   logic [3:0]        step_k;
   logic              in_ready_reg;
   logic              out_valid_reg;
   logic [MAN_W-1:0]  man_big_reg;
   logic [WORD_W-1:0] man_small_reg;
   logic [7:0]        exp_reg;
   logic              swapped_reg;

   assign rem_load = clamp_shift(expdiff);
   assign step_k   = (rem_reg >= REM_W'(SHIFT_STEP)) ? 4'(SHIFT_STEP) : rem_reg[3:0];
   assign rem_next = rem_reg - {1'b0, step_k};

   sticky_rshift u_shift (
      .word    (work_reg),
      .k       (step_k),
      .shifted (work_next)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         work_reg      <= '0;
         rem_reg       <= '0;
         in_ready_reg  <= 1'b1;
         out_valid_reg <= 1'b0;
         man_big_reg   <= '0;
         man_small_reg <= '0;
         exp_reg       <= '0;
         swapped_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (in_valid) begin
                  man_big_reg  <= muxctrl ? manB : manA;
                  work_reg     <= {(muxctrl ? manA : manB), 3'b000};
                  rem_reg      <= rem_load;
                  exp_reg      <= expbig;
                  swapped_reg  <= muxctrl;
                  in_ready_reg <= 1'b0;
                  state_reg    <= (rem_load == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               work_reg <= work_next;
               rem_reg  <= rem_next;
               if (rem_next == '0)
                  state_reg <= DONE;
            end
            DONE: begin
               // Result is published one cycle after the shift finishes, then held until taken.
               if (!out_valid_reg) begin
                  out_valid_reg <= 1'b1;
                  man_small_reg <= work_reg;
               end else if (out_ready) begin
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
                  state_reg     <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign man_big   = man_big_reg;
   assign man_small = man_small_reg;
   assign exp_out   = exp_reg;
   assign swapped   = swapped_reg;
endmodule

// File: tb/tb_mant_align_shift.sv
// Directed-vector bench for mant_align_shift with hand-computed alignment results and latencies.
module tb_mant_align_shift;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [23:0] manA = '0;
   logic [23:0] manB = '0;
   logic [7:0]  expbig = '0;
   logic [7:0]  expdiff = '0;
   logic        muxctrl = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [23:0] man_big;
   logic [26:0] man_small;
   logic [7:0]  exp_out;
   logic        swapped;

   int vectors = 0;
   int miscompares = 0;

   mant_align_shift #(.SHIFT_STEP(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .manA      (manA),
      .manB      (manB),
      .expbig    (expbig),
      .expdiff   (expdiff),
      .muxctrl   (muxctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .man_big   (man_big),
      .man_small (man_small),
      .exp_out   (exp_out),
      .swapped   (swapped)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // One operation: accept, count cycles to out_valid, optionally stall, then hand off.
   task automatic run_op(input string tag, input logic mux, input logic [23:0] a,
                         input logic [23:0] b, input logic [7:0] eb, input logic [7:0] ed,
                         input logic [26:0] exp_small, input int exp_lat, input int hold);
      logic [23:0] exp_big;
      int cyc;
      exp_big = mux ? b : a;
      check({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
      muxctrl = mux; manA = a; manB = b; expbig = eb; expdiff = ed; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      manA = 24'($urandom); manB = 24'($urandom);
      expbig = 8'($urandom); expdiff = 8'($urandom); muxctrl = ~mux;
      check({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
      cyc = 0;
      while (!out_valid && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
      check({tag, ".man_big"}, 32'(man_big), 32'(exp_big));
      check({tag, ".man_small"}, 32'(man_small), 32'(exp_small));
      check({tag, ".exp_out"}, 32'(exp_out), 32'(eb));
      check({tag, ".swapped"}, 32'(swapped), 32'(mux));
      for (int i = 0; i < hold; i++) begin
         in_valid = (i % 2 == 0);
         manA = 24'($urandom); manB = 24'($urandom); expdiff = 8'($urandom);
         @(posedge clk); #1;
         check({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
         check({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
         check({tag, ".hold_small"}, 32'(man_small), 32'(exp_small));
         check({tag, ".hold_big"}, 32'(man_big), 32'(exp_big));
      end
      in_valid = 1'b0;
      check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".valid_drop"}, 32'(out_valid), 32'd0);
      check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
      $display("op %s: mux=%0d ed=%0d small=%h lat=%0d", tag, mux, ed, man_small, cyc);
   endtask

   initial begin
      #12;
      check("reset.in_ready", 32'(in_ready), 32'd1);
      check("reset.out_valid", 32'(out_valid), 32'd0);
      check("reset.man_small", 32'(man_small), 32'd0);
      check("reset.man_big", 32'(man_big), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op("t1_ed1",    1'b0, 24'hC00000, 24'h800000, 8'h85, 8'd1,   27'h2000000, 2, 0);
      run_op("t2_swap",   1'b1, 24'h800001, 24'hFFFFFF, 8'h90, 8'd3,   27'h0800001, 2, 0);
      run_op("t3_ed0",    1'b0, 24'h123456, 24'hABCDEF, 8'h7F, 8'd0,   27'h55E6F78, 1, 0);
      run_op("t4_ed10",   1'b0, 24'h800000, 24'hC00000, 8'h10, 8'd10,  27'h0018000, 4, 0);
      run_op("t4_ed40",   1'b0, 24'hFFFFFF, 24'h800000, 8'h40, 8'd40,  27'h0000001, 8, 0);
      run_op("sat_ed26",  1'b0, 24'h000001, 24'hFFFFFF, 8'h26, 8'd26,  27'h0000001, 8, 0);
      run_op("ed25",      1'b0, 24'h000001, 24'h800000, 8'h25, 8'd25,  27'h0000002, 8, 0);
      run_op("zero_255",  1'b1, 24'h000000, 24'h800000, 8'hFF, 8'd255, 27'h0000000, 8, 0);
      run_op("stk_ed4",   1'b0, 24'hFFFFFF, 24'h000001, 8'h04, 8'd4,   27'h0000001, 2, 0);
      run_op("stk_ed5",   1'b0, 24'hFFFFFF, 24'h000003, 8'h05, 8'd5,   27'h0000001, 3, 0);
      run_op("ed8_ones",  1'b0, 24'h800000, 24'hFFFFFF, 8'h08, 8'd8,   27'h007FFFF, 3, 0);
      run_op("t5_stall",  1'b0, 24'h123456, 24'hFEDCBA, 8'h55, 8'd2,   27'h1FDB974, 2, 5);
      @(posedge clk); #1;
      check("t5.no_ghost_op", 32'(out_valid), 32'd0);

      // Asynchronous reset in the middle of a long shift.
      muxctrl = 1'b0; manA = 24'hFFFFFF; manB = 24'hFFFFFF; expbig = 8'h33; expdiff = 8'd40;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("t6.in_ready", 32'(in_ready), 32'd1);
      check("t6.out_valid", 32'(out_valid), 32'd0);
      check("t6.man_big", 32'(man_big), 32'd0);
      check("t6.exp_out", 32'(exp_out), 32'd0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("t6_after",  1'b1, 24'h800000, 24'hC00000, 8'h21, 8'd1,   27'h2000000, 2, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
